cpu_alu_mc: RTL and testbench

Multi-cycle, width-parametrised integer execute unit. It combines the base ALU operations with an iterative RV32M multiply/divide datapath and an optional serial shifter. It sits in the execute stage of the core. Requests enter through a valid/ready handshake, and results are held registered until the pipeline accepts them, so the stage can stall on long operations.

---
 rtl/cpu_alu_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_cpu_alu_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_mc.sv
// cpu_alu_mc: multi-cycle integer execute unit (base ALU, iterative RV32M
// multiply/divide, optional bit-serial shifter) with valid/ready on both sides.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_flush                synchronous abort of any in-flight op
//   i_valid/o_ready        request handshake (o_ready only in IDLE)
//   i_op, i_op_a, i_op_b   opcode and operands, latched on accept
//   o_valid/i_ready        result handshake (o_valid only in DONE)
//   o_out, o_null_out      registered result and its zero flag
//   o_ops_eq/lt/ltu        combinational compares of the live operands
module cpu_alu_mc #(
  parameter int unsigned p_xlen         = 32,
  parameter bit          p_ext_rvm      = 1'b1,
  parameter bit          p_serial_shift = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_op,
  input  logic [p_xlen-1:0] i_op_a,
  input  logic [p_xlen-1:0] i_op_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [p_xlen-1:0] o_out,
  output logic              o_null_out,
  output logic              o_ops_eq,
  output logic              o_ops_lt,
  output logic              o_ops_ltu
);

  localparam int unsigned LP_SHW = $clog2(p_xlen);
  localparam int unsigned LP_CW  = LP_SHW + 1;
  localparam int unsigned LP_PW  = 2 * p_xlen;
  localparam logic [p_xlen-1:0] LP_MIN = {1'b1, {(p_xlen-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LP_CW-1:0]  cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [p_xlen-1:0] opb_q, opb_d;     // multiplicand / divisor magnitude
  logic [LP_PW-1:0]  prod_q, prod_d;   // {hi, lo} work register shared by all iterative ops
  logic              negq_q, negq_d;   // negate product / quotient on exit
  logic              negr_q, negr_d;   // negate remainder on exit
  logic [p_xlen-1:0] out_q, out_d;
  logic              null_q, ready_q, valid_q;

  // Request decode and operand magnitudes
  logic              in_shift, in_mul, in_div, sa_in, sb_in, neg_a, neg_b;
  logic              b_zero, div_ovf;
  logic [LP_SHW-1:0] shamt;
  logic [p_xlen-1:0] mag_a, mag_b;

  assign in_shift = (i_op == 5'd7) || (i_op == 5'd8) || (i_op == 5'd9);
  assign in_mul   = p_ext_rvm && (i_op[4:2] == 3'b100);
  assign in_div   = p_ext_rvm && (i_op[4:2] == 3'b101);
  assign sa_in    = in_mul ? (i_op[1:0] != 2'b11) : ~i_op[0];
  assign sb_in    = in_mul ? ~i_op[1] : ~i_op[0];
  assign neg_a    = sa_in & i_op_a[p_xlen-1];
  assign neg_b    = sb_in & i_op_b[p_xlen-1];
  assign mag_a    = neg_a ? -i_op_a : i_op_a;
  assign mag_b    = neg_b ? -i_op_b : i_op_b;
  assign shamt    = i_op_b[LP_SHW-1:0];
  assign b_zero   = (i_op_b == '0);
  assign div_ovf  = ~i_op[0] & (i_op_a == LP_MIN) & (&i_op_b);

  // Single-cycle base operations; unknown codes yield zero
  function automatic logic [p_xlen-1:0] f_base(input logic [4:0] op,
                                               input logic [p_xlen-1:0] a,
                                               input logic [p_xlen-1:0] b);
    logic [LP_SHW-1:0] sh;
    sh = b[LP_SHW-1:0];
    case (op)
      5'd0:    f_base = a + b;
      5'd1:    f_base = a - b;
      5'd2:    f_base = a & b;
      5'd3:    f_base = a | b;
      5'd4:    f_base = a ^ b;
      5'd5:    f_base = {{(p_xlen-1){1'b0}}, $signed(a) < $signed(b)};
      5'd6:    f_base = {{(p_xlen-1){1'b0}}, a < b};
      5'd7:    f_base = a << sh;
      5'd8:    f_base = a >> sh;
      5'd9:    f_base = $signed(a) >>> sh;
      5'd10:   f_base = a;
      5'd11:   f_base = b;
      default: f_base = '0;
    endcase
  endfunction

  // Shift-add multiply step: add multiplicand on lsb, then shift right
  logic [p_xlen:0]       mul_sum;
  logic [LP_PW-1:0]      mul_next, mul_fix;
  logic [p_xlen-1:0]     mul_res;
  assign mul_sum  = {1'b0, prod_q[LP_PW-1:p_xlen]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, prod_q[p_xlen-1:1]};
  assign mul_fix  = negq_q ? -mul_next : mul_next;
  assign mul_res  = (op_q[1:0] == 2'b00) ? mul_fix[p_xlen-1:0] : mul_fix[LP_PW-1:p_xlen];

  // Restoring divide step: shift {rem, quot} left, trial-subtract divisor
  logic [p_xlen:0]   div_sh, div_diff;
  logic              div_ok;
  logic [LP_PW-1:0]  div_next;
  logic [p_xlen-1:0] div_quo, div_rem, div_res;
  assign div_sh   = prod_q[LP_PW-1:p_xlen-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ok   = ~div_diff[p_xlen];
  assign div_next = {(div_ok ? div_diff[p_xlen-1:0] : div_sh[p_xlen-1:0]),
                     prod_q[p_xlen-2:0], div_ok};
  assign div_quo  = div_next[p_xlen-1:0];
  assign div_rem  = div_next[LP_PW-1:p_xlen];
  assign div_res  = op_q[1] ? (negr_q ? -div_rem : div_rem) : (negq_q ? -div_quo : div_quo);

  // One-bit serial shift step
  logic [p_xlen-1:0] sh_v, sh_next;
  assign sh_v    = prod_q[p_xlen-1:0];
  assign sh_next = (op_q == 5'd7) ? {sh_v[p_xlen-2:0], 1'b0} :
                   (op_q == 5'd8) ? {1'b0, sh_v[p_xlen-1:1]} :
                                    {sh_v[p_xlen-1], sh_v[p_xlen-1:1]};

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    out_d   = out_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d    = i_op;
            state_d = S_DONE;
            if (in_shift && p_serial_shift) begin
              if (shamt == '0) begin
                out_d = i_op_a;
              end else begin
                state_d = S_SHIFT;
                cnt_d   = LP_CW'(shamt);
                prod_d  = {{p_xlen{1'b0}}, i_op_a};
              end
            end else if (in_mul) begin
              state_d = S_MUL;
              cnt_d   = LP_CW'(p_xlen);
              prod_d  = {{p_xlen{1'b0}}, mag_a};
              opb_d   = mag_b;
              negq_d  = neg_a ^ neg_b;
            end else if (in_div) begin
              if (b_zero) begin
                out_d = i_op[1] ? i_op_a : '1;
              end else if (div_ovf) begin
                out_d = i_op[1] ? '0 : i_op_a;
              end else begin
                state_d = S_DIV;
                cnt_d   = LP_CW'(p_xlen);
                prod_d  = {{p_xlen{1'b0}}, mag_a};
                opb_d   = mag_b;
                negq_d  = neg_a ^ neg_b;
                negr_d  = neg_a;
              end
            end else begin
              out_d = f_base(i_op, i_op_a, i_op_b);
            end
          end
        end
        S_SHIFT: begin
          prod_d = {{p_xlen{1'b0}}, sh_next};
          cnt_d  = cnt_q - LP_CW'(1);
          if (cnt_q == LP_CW'(1)) begin
            out_d   = sh_next;
            state_d = S_DONE;
          end
        end
        S_MUL: begin
          prod_d = mul_next;
          cnt_d  = cnt_q - LP_CW'(1);
          if (cnt_q == LP_CW'(1)) begin
            out_d   = mul_res;
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          prod_d = div_next;
          cnt_d  = cnt_q - LP_CW'(1);
          if (cnt_q == LP_CW'(1)) begin
            out_d   = div_res;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      null_q  <= 1'b1;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      prod_q  <= prod_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
      null_q  <= (out_d == '0);
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_DONE);
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_out      = out_q;
  assign o_null_out = null_q;
  assign o_ops_eq   = (i_op_a == i_op_b);
  assign o_ops_lt   = ($signed(i_op_a) < $signed(i_op_b));
  assign o_ops_ltu  = (i_op_a < i_op_b);

endmodule

// File: tb/tb_cpu_alu_mc.sv
// tb_cpu_alu_mc: directed and randomized checks of cpu_alu_mc against an
// arithmetic reference model; one barrel-shift instance, one serial-shift.
module tb_cpu_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n, flush, rdy;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        v0, vs;
  logic        r0, val0, null0, eq0, lt0, ltu0;
  logic        rs, vals, nulls, eqs, lts, ltus;
  logic [31:0] out0, outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_alu_mc #(.p_xlen(32), .p_ext_rvm(1'b1), .p_serial_shift(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(v0), .o_ready(r0),
    .i_op(op), .i_op_a(a), .i_op_b(b), .o_valid(val0), .i_ready(rdy),
    .o_out(out0), .o_null_out(null0), .o_ops_eq(eq0), .o_ops_lt(lt0), .o_ops_ltu(ltu0));

  cpu_alu_mc #(.p_xlen(32), .p_ext_rvm(1'b1), .p_serial_shift(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vs), .o_ready(rs),
    .i_op(op), .i_op_a(a), .i_op_b(b), .o_valid(vals), .i_ready(rdy),
    .o_out(outs), .o_null_out(nulls), .o_ops_eq(eqs), .o_ops_lt(lts), .o_ops_ltu(ltus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from the opcode table with 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd6:  return (x < y) ? 32'd1 : 32'd0;
      5'd7:  return x << y[4:0];
      5'd8:  return x >> y[4:0];
      5'd9:  return $signed(x) >>> y[4:0];
      5'd10: return x;
      5'd11: return y;
      5'd16: begin p = sx * sy; return p[31:0]; end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = ux * uy; return p[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        p = sx / sy; return p[31:0];
      end
      5'd21: return (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Reference latency in cycles from accept edge to o_valid
  function automatic int ref_lat(input bit sel, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 5'd7 || o == 5'd8 || o == 5'd9) return sel ? 1 + int'(y[4:0]) : 1;
    if (o[4:3] == 2'b10) begin
      if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
      return 33;
    end
    return 1;
  endfunction

  // One full transaction; hold = cycles to keep i_ready low after o_valid
  task automatic run_op(input bit sel, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int hold, input string tag);
    logic [31:0] exp;
    int lat, k;
    exp = ref_res(o, x, y);
    lat = ref_lat(sel, o, x, y);
    @(negedge clk);
    op = o; a = x; b = y;
    if (sel) vs = 1'b1; else v0 = 1'b1;
    chk({tag, "_rdy_pre"}, {31'b0, sel ? rs : r0}, 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0; vs = 1'b0;
    op = 5'($urandom); a = $urandom; b = $urandom;
    k = 0;
    while (!(sel ? vals : val0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat - 1));
    chk({tag, "_out"}, sel ? outs : out0, exp);
    chk({tag, "_null"}, {31'b0, sel ? nulls : null0}, {31'b0, exp == 0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {sel ? outs : out0, 31'b0, sel ? rs : r0}, {exp, 32'd0});
      chk({tag, "_holdv"}, {31'b0, sel ? vals : val0}, 32'd1);
    end
    @(negedge clk); rdy = 1'b1;
    @(posedge clk); #1; rdy = 1'b0;
    chk({tag, "_rel"}, {30'b0, sel ? vals : val0, sel ? rs : r0}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [4:0] ro;
    logic [31:0] ra, rb;
    bit rsel;
    rst_n = 1'b0; flush = 1'b0; rdy = 1'b0; v0 = 1'b0; vs = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    chk("rst_state", {out0, 28'b0, r0, val0, null0, 1'b0}, {32'd0, 28'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_rdy", {31'b0, r0 & rs}, 32'd1);

    // Combinational compares on the live inputs
    a = 32'd5; b = 32'd5; #1;
    chk("cmp_eq", {29'b0, eq0, lt0, ltu0}, 32'b100);
    a = 32'hFFFFFFFF; b = 32'd1; #1;
    chk("cmp_neg", {29'b0, eq0, lt0, ltu0}, 32'b010);
    a = 32'd1; b = 32'hFFFFFFFF; #1;
    chk("cmp_big", {29'b0, eqs, lts, ltus}, 32'b001);

    run_op(0, 5'd0,  32'h7FFFFFFF, 32'd1, 0, "add_wrap");
    run_op(0, 5'd1,  32'd5, 32'd5, 0, "sub_zero");
    run_op(0, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu");
    run_op(0, 5'd17, 32'hFFFFFFFF, 32'd2, 0, "mulh");
    run_op(0, 5'd16, -32'sd3, 32'd7, 0, "mul");
    run_op(0, 5'd18, 32'h80000000, 32'hFFFFFFFF, 0, "mulhsu");
    run_op(0, 5'd20, 32'h12345678, 32'd0, 0, "div_by0");
    run_op(0, 5'd22, 32'h12345678, 32'd0, 0, "rem_by0");
    run_op(0, 5'd20, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
    run_op(0, 5'd22, 32'h80000000, 32'hFFFFFFFF, 0, "rem_ovf");
    run_op(0, 5'd20, -32'sd7, 32'd2, 0, "div_neg");
    run_op(0, 5'd22, -32'sd7, 32'd2, 0, "rem_neg");
    run_op(0, 5'd21, 32'hFFFFFFFE, 32'd2, 0, "divu");
    run_op(0, 5'd9,  32'h80000000, 32'd31, 0, "sra_barrel");
    run_op(1, 5'd9,  32'h80000000, 32'd31, 0, "sra_serial");
    run_op(1, 5'd7,  32'hA5A5_1234, 32'd0, 0, "sll_serial0");
    run_op(1, 5'd8,  32'hF000_000F, 32'd4, 0, "srl_serial");
    run_op(0, 5'd12, 32'h1234, 32'h5678, 0, "undef_op");
    run_op(0, 5'd5,  32'hFFFFFFFF, 32'd1, 10, "slt_backpressure");

    // Flush mid-divide: the result must never appear
    @(negedge clk); op = 5'd21; a = 32'hDEADBEEF; b = 32'd3; v0 = 1'b1;
    @(posedge clk); #1; v0 = 1'b0;
    seen = 1'b0;
    repeat (9) begin @(posedge clk); #1; if (val0) seen = 1'b1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_state", {30'b0, val0, r0}, 32'b01);
    repeat (30) begin @(posedge clk); #1; if (val0) seen = 1'b1; end
    chk("flush_no_valid", {31'b0, seen}, 32'd0);

    // Request coincident with flush is ignored
    @(negedge clk); op = 5'd0; a = 32'd1; b = 32'd2; v0 = 1'b1; flush = 1'b1;
    @(posedge clk); #1; v0 = 1'b0; flush = 1'b0;
    chk("flush_accept", {30'b0, val0, r0}, 32'b01);
    @(posedge clk); #1;
    chk("flush_accept2", {30'b0, val0, r0}, 32'b01);

    // Asynchronous reset in the middle of a multiply
    run_op(0, 5'd3, 32'h00F0_0000, 32'h0000_0F00, 0, "or_pre_rst");
    @(negedge clk); op = 5'd16; a = 32'd12345; b = 32'd678; v0 = 1'b1;
    @(posedge clk); #1; v0 = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("rst_mid_mul", {out0, 29'b0, val0, null0, r0}, {32'd0, 29'b0, 3'b011});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_mul_rel", {30'b0, val0, r0}, 32'b01);

    // Randomized operations on both instances
    for (int i = 0; i < 80; i++) begin
      rsel = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op(rsel, ro, ra, rb, 0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
